// File: rtl/clock_pkg.sv
// Shared ASCII constants, frame layout, TX bit-state encoding and digit encoder.
// Latency/backpressure: n/a (definitions only).
package clock_pkg;

    localparam logic [7:0] ASCII_0 = 8'h30;
    localparam logic [7:0] COLON   = 8'h3A;
    localparam logic [7:0] SPACE   = 8'h20;
    localparam logic [7:0] CHAR_A  = 8'h41;
    localparam logic [7:0] QMARK   = 8'h3F;
    localparam logic [7:0] CR      = 8'h0D;
    localparam logic [7:0] LF      = 8'h0A;

    localparam int         FRAME_LEN = 8;
    localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_DATA  = 2'd2;
    localparam logic [1:0] ST_STOP  = 2'd3;

    // Everything the frame needs, captured in one edge so mid-frame input changes are invisible.
    typedef struct packed {
        logic [1:0] hr_tens;
        logic [3:0] hr_units;
        logic [2:0] min_tens;
        logic [3:0] min_units;
        logic       alarm;
    } snap_t;

    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d > 4'd9) ? QMARK : (ASCII_0 + {4'b0000, d});
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start accepted while ready puts tx low on the next edge.
// ready rises in the last stop-bit cycle so back-to-back bytes have no idle gap.
module uart_tx_byte
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == CW'(CLKS_PER_BIT - 1));
    assign ready   = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else if (ready && start) begin
            state    <= ST_START;
            tx       <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= data;
        end else begin
            if (state != ST_IDLE) begin
                baud_cnt <= bit_end ? '0 : (baud_cnt + 1'b1);
            end
            if (bit_end) begin
                case (state)
                    ST_START: begin
                        state <= ST_DATA;
                        tx    <= shreg[0];
                    end
                    ST_DATA: begin
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // shreg[0] is the bit on the line; shift the next one down
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end
                    ST_STOP: begin
                        state <= ST_IDLE;
                        tx    <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_time_reporter.sv
// Sends "HH:MMf\r\n" over UART on request or minute change; tx low one edge after trigger.
// One frame may be queued while busy (pending); further triggers are dropped.
module uart_time_reporter
    import clock_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] hr_tens,
    input  logic [3:0] hr_units,
    input  logic [2:0] min_tens,
    input  logic [3:0] min_units,
    input  logic       alarm_flag,
    input  logic       send_req,
    input  logic       auto_en,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    logic [6:0] cur_min;
    logic [6:0] prev_min;
    logic       trigger;
    logic       active;
    logic       all_loaded;
    logic       pending;
    logic [2:0] byte_idx;
    snap_t      snap;
    logic [7:0] byte_dat;
    logic       tx_ready;
    logic       tx_start;
    logic       complete;

    assign cur_min = {min_tens, min_units};
    assign trigger = send_req | (auto_en & (cur_min != prev_min));

    // All bytes handed over and the byte unit is in its final stop-bit cycle.
    assign tx_start = active & ~all_loaded & tx_ready;
    assign complete = active & all_loaded & tx_ready;

    always_comb begin
        byte_dat = LF;
        case (byte_idx)
            3'd0: byte_dat = digit_ascii({2'b00, snap.hr_tens});
            3'd1: byte_dat = digit_ascii(snap.hr_units);
            3'd2: byte_dat = COLON;
            3'd3: byte_dat = digit_ascii({1'b0, snap.min_tens});
            3'd4: byte_dat = digit_ascii(snap.min_units);
            3'd5: byte_dat = snap.alarm ? CHAR_A : SPACE;
            3'd6: byte_dat = CR;
            default: byte_dat = LF;
        endcase
    end

    always_ff @(posedge clk) begin
        prev_min <= cur_min;
        if (reset) begin
            active     <= 1'b0;
            all_loaded <= 1'b0;
            pending    <= 1'b0;
            byte_idx   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            snap       <= '0;
        end else begin
            done <= 1'b0;
            if (tx_start) begin
                busy     <= 1'b1;
                byte_idx <= byte_idx + 3'd1;
                if (byte_idx == LAST_BYTE) begin
                    all_loaded <= 1'b1;
                end
            end
            if (!active || complete) begin
                if (complete) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
                // A queued or coincident trigger relaunches here, leaving one idle-high cycle.
                if (trigger || pending) begin
                    snap       <= '{hr_tens:   hr_tens,
                                    hr_units:  hr_units,
                                    min_tens:  min_tens,
                                    min_units: min_units,
                                    alarm:     alarm_flag};
                    active     <= 1'b1;
                    all_loaded <= 1'b0;
                    byte_idx   <= '0;
                    pending    <= 1'b0;
                end else begin
                    active <= 1'b0;
                end
            end else if (trigger) begin
                pending <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) u_tx (
        .clk   (clk),
        .reset (reset),
        .start (tx_start),
        .data  (byte_dat),
        .tx    (tx),
        .ready (tx_ready)
    );

endmodule

// File: tb/tb_uart_time_reporter.sv
// Randomised scoreboard bench: a frame-level timing model queues expected bytes, a UART receiver checks them.
module tb_uart_time_reporter;

    localparam int CPB       = 16;
    localparam int FRAME_CYC = 80 * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] hr_tens;
    logic [3:0] hr_units;
    logic [2:0] min_tens;
    logic [3:0] min_units;
    logic       alarm_flag;
    logic       send_req;
    logic       auto_en;
    logic       tx;
    logic       busy;
    logic       done;

    typedef struct {
        logic [7:0] val;
        int         start;
    } exp_byte_t;

    exp_byte_t byte_q[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    bit exp_busy = 1'b0;
    bit exp_done = 1'b0;

    always #5 clk = ~clk;

    uart_time_reporter #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .hr_tens    (hr_tens),
        .hr_units   (hr_units),
        .min_tens   (min_tens),
        .min_units  (min_units),
        .alarm_flag (alarm_flag),
        .send_req   (send_req),
        .auto_en    (auto_en),
        .tx         (tx),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] dig(input int d);
        return (d > 9) ? 8'h3F : 8'(48 + d);
    endfunction

    // Reference model: frame start/end times as plain arithmetic, one queued frame at most.
    initial begin
        int  fend;
        int  fstart;
        bit  mpend;
        bit  trig;
        int  mprev;
        logic [7:0] fb[8];
        fend = -1; fstart = -1; mpend = 0; mprev = 0;
        forever begin
            @(posedge clk);
            cyc++;
            exp_done = 1'b0;
            if (reset) begin
                fend = -1; fstart = -1; mpend = 0;
                mprev = {min_tens, min_units};
                byte_q.delete();
            end else begin
                trig  = send_req || (auto_en && (int'({min_tens, min_units}) != mprev));
                mprev = {min_tens, min_units};
                if (fend == cyc) exp_done = 1'b1;
                if (fend >= cyc && trig) mpend = 1;
                if (fend <= cyc && (trig || mpend)) begin
                    fb[0] = dig(int'(hr_tens));
                    fb[1] = dig(int'(hr_units));
                    fb[2] = 8'h3A;
                    fb[3] = dig(int'(min_tens));
                    fb[4] = dig(int'(min_units));
                    fb[5] = alarm_flag ? 8'h41 : 8'h20;
                    fb[6] = 8'h0D;
                    fb[7] = 8'h0A;
                    for (int k = 0; k < 8; k++)
                        byte_q.push_back('{val: fb[k], start: cyc + 1 + k * 10 * CPB});
                    fstart = cyc;
                    fend   = cyc + 1 + FRAME_CYC;
                    mpend  = 0;
                end
            end
            exp_busy = (fend > cyc) && (cyc > fstart);
        end
    end

    // Monitor: per-cycle done/busy/idle checks plus a mid-bit sampling UART receiver.
    initial begin
        bit         rx_active;
        int         rx_t;
        int         rx_st;
        logic [7:0] rx_byte;
        exp_byte_t  e;
        rx_active = 0; rx_t = 0; rx_st = 0; rx_byte = '0;
        forever begin
            @(posedge clk);
            #1;
            check("done", int'(done), int'(exp_done));
            check("busy", int'(busy), int'(exp_busy));
            if (!exp_busy) check("tx_idle", int'(tx), 1);
            if (reset) begin
                rx_active = 0;
            end else if (!rx_active) begin
                if (tx == 1'b0) begin
                    rx_active = 1; rx_t = 0; rx_st = cyc;
                end
            end else begin
                rx_t++;
                if (rx_t == 8) begin
                    check("start_bit", int'(tx), 0);
                end else if (rx_t >= 24 && rx_t <= 136 && ((rx_t - 8) % 16) == 0) begin
                    rx_byte[3'((rx_t - 24) / 16)] = tx;
                end else if (rx_t == 152) begin
                    check("stop_bit", int'(tx), 1);
                    if (byte_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_byte: got %02h expected none at cycle %0d", rx_byte, cyc);
                    end else begin
                        e = byte_q.pop_front();
                        check("byte_val", int'(rx_byte), int'(e.val));
                        check("byte_start", rx_st, e.start);
                    end
                    rx_active = 0;
                end
            end
        end
    end

    task automatic pulse_req();
        @(negedge clk) send_req = 1'b1;
        @(negedge clk) send_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_time(input int ht, input int hu, input int mt, input int mu, input bit al);
        @(negedge clk);
        hr_tens = 2'(ht); hr_units = 4'(hu); min_tens = 3'(mt); min_units = 4'(mu); alarm_flag = al;
    endtask

    task automatic rand_time();
        set_time($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                 $urandom_range(0, 15), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        int guard;
        reset = 1'b1; send_req = 1'b0; auto_en = 1'b0;
        hr_tens = 2'd0; hr_units = 4'd0; min_tens = 3'd0; min_units = 4'd0; alarm_flag = 1'b0;
        idle(3);
        reset = 1'b0;

        set_time(1, 2, 3, 4, 0);
        idle(6);
        pulse_req();
        idle(1300);

        set_time(0, 9, 5, 9, 1);
        pulse_req();
        idle(400);
        rand_time();
        idle(900);

        set_time(1, 1, 5, 9, 0);
        auto_en = 1'b1;
        idle(5);
        set_time(1, 1, 0, 0, 0);
        idle(1300);
        auto_en = 1'b0;
        set_time(1, 1, 5, 9, 0);
        idle(5);
        set_time(1, 1, 0, 0, 0);
        idle(100);

        set_time(2, 3, 4, 5, 1);
        pulse_req();
        idle(50);
        pulse_req();
        idle(100);
        pulse_req();
        idle(100);
        pulse_req();
        idle(2700);

        set_time(1, 12, 2, 7, 0);
        pulse_req();
        idle(1300);

        set_time(2, 0, 1, 8, 1);
        pulse_req();
        idle(300);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        idle(20);
        set_time(0, 5, 3, 0, 0);
        pulse_req();
        idle(1300);

        pulse_req();
        idle(1280);
        pulse_req();
        idle(2700);

        for (int i = 0; i < 12000; i++) begin
            @(negedge clk);
            send_req = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 599) == 0) begin
                hr_tens = 2'($urandom_range(0, 3)); hr_units = 4'($urandom_range(0, 15));
                min_tens = 3'($urandom_range(0, 7)); min_units = 4'($urandom_range(0, 15));
                alarm_flag = 1'($urandom_range(0, 1));
            end
            if (i % 2000 == 0) auto_en = 1'($urandom_range(0, 1));
        end
        send_req = 1'b0; auto_en = 1'b0;

        guard = 0;
        while ((byte_q.size() != 0 || busy) && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        idle(200);
        check("queue_drained", byte_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
